// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor datapath and its control FSM:
// next-PC select encodings, instruction field positions and opcode values.
package cpu_pkg;

    // Next-PC source select driven by the control FSM
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_source_e;

    // Instruction field bit positions within IR
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;
    localparam int RS_HI     = 25;
    localparam int RS_LO     = 21;
    localparam int RT_HI     = 20;
    localparam int RT_LO     = 16;
    localparam int RD_HI     = 15;
    localparam int RD_LO     = 11;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;
    localparam int JADDR_HI  = 25;
    localparam int JADDR_LO  = 0;

    localparam int OPCODE_W  = OPCODE_HI - OPCODE_LO + 1;
    localparam int REG_W     = RS_HI - RS_LO + 1;
    localparam int IMM_W     = IMM_HI - IMM_LO + 1;
    localparam int JADDR_W   = JADDR_HI - JADDR_LO + 1;

    // Opcodes shared with the control FSM (one-hot)
    localparam logic [OPCODE_W-1:0] OP_JUMP   = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_SW     = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_LW     = 6'b010000;

endpackage

// File: rtl/pc_unit.sv
// Program counter: write-enable qualification, next-PC selection and the PC
// register itself. All mux inputs are pre-edge register values.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write,
    input  logic                pc_write_cond,
    input  logic [1:0]          pc_source,
    input  logic                alu_zero,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   alu_out_q,
    input  logic [JADDR_W-1:0]  jaddr,
    output logic [DATA_W-1:0]   pc_q
);

    logic                pc_en;
    logic [DATA_W-1:0]   jump_target;
    logic [DATA_W-1:0]   pc_next;

    // Unconditional write dominates; the conditional write needs the zero flag
    always_comb begin
        pc_en = pc_write | (pc_write_cond & alu_zero);
    end

    // Jump keeps the upper region bits of the current PC and replaces the
    // low bits with the word-aligned jump field
    always_comb begin
        jump_target                = pc_q;
        jump_target[JADDR_W+1:0]   = {jaddr, 2'b00};
    end

    // Next-PC select; the reserved encoding holds even when a write is enabled
    always_comb begin
        pc_next = pc_q;
        if (pc_en) begin
            case (pc_source)
                PCSRC_ALU:    pc_next = alu_result;
                PCSRC_ALUOUT: pc_next = alu_out_q;
                PCSRC_JUMP:   pc_next = jump_target;
                default:      pc_next = pc_q;
            endcase
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_datapath.sv
// Fetch/decode datapath of the multicycle processor: PC (via pc_unit), IR,
// MDR and ALUOut registers, memory address select, instruction field slicing
// and a retired-instruction counter for debug.
module fetch_datapath
    import cpu_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  PC_RESET = 32'h0000_0000,
    parameter int                 CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic [1:0]           pc_source,
    input  logic                 iord,
    input  logic                 mem_read,
    input  logic                 ir_write,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    pc_q,
    output logic [DATA_W-1:0]    ir_q,
    output logic [DATA_W-1:0]    mdr_q,
    output logic [DATA_W-1:0]    alu_out_q,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [REG_W-1:0]     rs,
    output logic [REG_W-1:0]     rt,
    output logic [REG_W-1:0]     rd,
    output logic [IMM_W-1:0]     imm,
    output logic [JADDR_W-1:0]   jaddr,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pc_unit #(
        .DATA_W   (DATA_W),
        .PC_RESET (PC_RESET)
    ) u_pc_unit (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_zero      (alu_zero),
        .alu_result    (alu_result),
        .alu_out_q     (alu_out_q),
        .jaddr         (jaddr),
        .pc_q          (pc_q)
    );

    // Instruction register, loaded from memory during fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q <= '0;
        end else if (ir_write) begin
            ir_q <= mem_rdata;
        end
    end

    // Memory data register, loaded on every memory read strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdr_q <= '0;
        end else if (mem_read) begin
            mdr_q <= mem_rdata;
        end
    end

    // ALUOut captures the ALU every cycle so the next state can use it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= alu_result;
        end
    end

    // Retired-instruction counter: one count per IR load, silent wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_count <= '0;
        end else if (ir_write) begin
            instr_count <= instr_count + CNT_ONE;
        end
    end

    // Memory address select, zero latency from iord
    always_comb begin
        mem_addr = iord ? alu_out_q : pc_q;
    end

    // Instruction field slices of the current IR
    always_comb begin
        opcode = ir_q[OPCODE_HI:OPCODE_LO];
        rs     = ir_q[RS_HI:RS_LO];
        rt     = ir_q[RT_HI:RT_LO];
        rd     = ir_q[RD_HI:RD_LO];
        imm    = ir_q[IMM_HI:IMM_LO];
        jaddr  = ir_q[JADDR_HI:JADDR_LO];
    end

endmodule

// File: tb/tb_fetch_datapath.sv
// Self-checking bench for fetch_datapath: directed scenarios plus a random
// run, all compared against a register-level reference model.
module tb_fetch_datapath;
    import cpu_pkg::*;

    localparam int CW = 4;
    localparam int CNT_MOD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_write, pc_write_cond, iord, mem_read, ir_write, alu_zero;
    logic [1:0]  pc_source;
    logic [31:0] alu_result, mem_rdata;

    logic [31:0]   mem_addr, pc_q, ir_q, mdr_q, alu_out_q;
    logic [5:0]    opcode;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [25:0]   jaddr;
    logic [CW-1:0] instr_count;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model state
    logic [31:0] m_pc, m_ir, m_mdr, m_alu_out;
    int          m_cnt;

    fetch_datapath #(
        .DATA_W   (32),
        .PC_RESET (32'h0000_0000),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .ir_write      (ir_write),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .mem_rdata     (mem_rdata),
        .mem_addr      (mem_addr),
        .pc_q          (pc_q),
        .ir_q          (ir_q),
        .mdr_q         (mdr_q),
        .alu_out_q     (alu_out_q),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm           (imm),
        .jaddr         (jaddr),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0; m_ir = 32'h0; m_mdr = 32'h0; m_alu_out = 32'h0; m_cnt = 0;
    endtask

    task automatic clear_inputs();
        pc_write = 0; pc_write_cond = 0; pc_source = 2'b00; iord = 0;
        mem_read = 0; ir_write = 0; alu_zero = 0;
        alu_result = 32'h0; mem_rdata = 32'h0;
    endtask

    // Advance one rising edge; model next values come from pre-edge inputs/state
    task automatic do_edge();
        logic [31:0] n_pc, n_ir, n_mdr, n_alu;
        int n_cnt;
        n_pc = m_pc;
        if (pc_write || (pc_write_cond && alu_zero)) begin
            if (pc_source == 2'd0)      n_pc = alu_result;
            else if (pc_source == 2'd1) n_pc = m_alu_out;
            else if (pc_source == 2'd2) n_pc = (m_pc & 32'hF000_0000) + (m_ir % 32'h0400_0000) * 4;
        end
        n_ir  = ir_write ? mem_rdata : m_ir;
        n_mdr = mem_read ? mem_rdata : m_mdr;
        n_alu = alu_result;
        n_cnt = ir_write ? (m_cnt + 1) % CNT_MOD : m_cnt;
        @(posedge clk);
        #1;
        m_pc = n_pc; m_ir = n_ir; m_mdr = n_mdr; m_alu_out = n_alu; m_cnt = n_cnt;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (pc_q !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc_q, 32'h0); end
        tests_run++; if (ir_q !== 32'h0) begin tests_failed++; $display("FAIL reset_ir: got %h expected %h", ir_q, 32'h0); end
        tests_run++; if (opcode !== 6'h0) begin tests_failed++; $display("FAIL reset_opcode: got %h expected %h", opcode, 6'h0); end
        tests_run++; if (instr_count !== 4'h0) begin tests_failed++; $display("FAIL reset_count: got %h expected %h", instr_count, 4'h0); end
        tests_run++; if (mdr_q !== 32'h0) begin tests_failed++; $display("FAIL reset_mdr: got %h expected %h", mdr_q, 32'h0); end
        rst = 1;
        do_edge();
        do_edge();
        tests_run++; if (pc_q !== 32'h0 || ir_q !== 32'h0 || instr_count !== 4'h0) begin
            tests_failed++; $display("FAIL reset_release_hold: got pc=%h ir=%h cnt=%h expected all zero", pc_q, ir_q, instr_count);
        end
        // load state, then abort mid-cycle with an asynchronous reset
        pc_write = 1; alu_result = 32'h1234_5678; ir_write = 1; mem_read = 1; mem_rdata = 32'hFFFF_FFFF;
        do_edge();
        clear_inputs();
        #2;
        rst = 0;
        model_reset();
        #1;
        tests_run++; if (pc_q !== 32'h0) begin tests_failed++; $display("FAIL async_reset_pc: got %h expected %h", pc_q, 32'h0); end
        tests_run++; if (ir_q !== 32'h0 || opcode !== 6'h0) begin tests_failed++; $display("FAIL async_reset_ir: got ir=%h op=%h expected 0", ir_q, opcode); end
        tests_run++; if (instr_count !== 4'h0) begin tests_failed++; $display("FAIL async_reset_count: got %h expected 0", instr_count); end
        tests_run++; if (alu_out_q !== 32'h0 || mdr_q !== 32'h0) begin tests_failed++; $display("FAIL async_reset_regs: got alu_out=%h mdr=%h expected 0", alu_out_q, mdr_q); end
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_fetch();
        clear_inputs();
        iord = 0; mem_rdata = 32'h0800_0004; ir_write = 1; mem_read = 1;
        pc_write = 1; pc_source = PCSRC_ALU; alu_result = 32'h4;
        #1;
        tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL fetch_addr_pre: got %h expected %h", mem_addr, 32'h0); end
        do_edge();
        tests_run++; if (ir_q !== 32'h0800_0004 || mdr_q !== 32'h0800_0004) begin tests_failed++; $display("FAIL fetch_ir_mdr: got ir=%h mdr=%h expected 08000004", ir_q, mdr_q); end
        tests_run++; if (opcode !== OP_BRANCH) begin tests_failed++; $display("FAIL fetch_opcode: got %b expected %b", opcode, OP_BRANCH); end
        tests_run++; if (pc_q !== 32'h4) begin tests_failed++; $display("FAIL fetch_pc: got %h expected %h", pc_q, 32'h4); end
        tests_run++; if (instr_count !== 4'd1) begin tests_failed++; $display("FAIL fetch_count: got %0d expected 1", instr_count); end
        tests_run++; if (mem_addr !== 32'h4) begin tests_failed++; $display("FAIL fetch_addr_post: got %h expected %h", mem_addr, 32'h4); end
    endtask

    task automatic test_branch();
        clear_inputs();
        alu_result = 32'h40;
        do_edge();
        pc_write_cond = 1; pc_source = PCSRC_ALUOUT; alu_zero = 1; alu_result = 32'h999;
        do_edge();
        tests_run++; if (pc_q !== 32'h40) begin tests_failed++; $display("FAIL branch_taken: got %h expected %h", pc_q, 32'h40); end
        tests_run++; if (alu_out_q !== 32'h999) begin tests_failed++; $display("FAIL branch_aluout: got %h expected %h", alu_out_q, 32'h999); end
        alu_zero = 0; alu_result = 32'h80;
        do_edge();
        tests_run++; if (pc_q !== 32'h40) begin tests_failed++; $display("FAIL branch_not_taken: got %h expected %h", pc_q, 32'h40); end
    endtask

    task automatic test_jump();
        clear_inputs();
        pc_write = 1; pc_source = PCSRC_ALU; alu_result = 32'hA000_0010;
        ir_write = 1; mem_rdata = {OP_JUMP, 26'h0000123};
        do_edge();
        tests_run++; if (jaddr !== 26'h0000123 || opcode !== OP_JUMP) begin tests_failed++; $display("FAIL jump_fields: got jaddr=%h op=%b expected 0000123/%b", jaddr, opcode, OP_JUMP); end
        clear_inputs();
        pc_write = 1; pc_source = PCSRC_JUMP;
        do_edge();
        tests_run++; if (pc_q !== 32'hA000_048C) begin tests_failed++; $display("FAIL jump_pc: got %h expected %h", pc_q, 32'hA000_048C); end
    endtask

    task automatic test_addr_priority();
        clear_inputs();
        alu_result = 32'h100;
        do_edge();
        iord = 1;
        #1;
        tests_run++; if (mem_addr !== 32'h100) begin tests_failed++; $display("FAIL addr_iord1: got %h expected %h", mem_addr, 32'h100); end
        iord = 0;
        #1;
        tests_run++; if (mem_addr !== m_pc) begin tests_failed++; $display("FAIL addr_iord0: got %h expected %h", mem_addr, m_pc); end
        pc_write = 1; pc_write_cond = 1; alu_zero = 0; pc_source = PCSRC_ALU; alu_result = 32'h200;
        do_edge();
        tests_run++; if (pc_q !== 32'h200) begin tests_failed++; $display("FAIL prio_write_dominates: got %h expected %h", pc_q, 32'h200); end
        pc_write = 1; pc_write_cond = 0; pc_source = PCSRC_RSVD; alu_result = 32'h300;
        do_edge();
        tests_run++; if (pc_q !== 32'h200) begin tests_failed++; $display("FAIL reserved_src_hold: got %h expected %h", pc_q, 32'h200); end
        pc_write = 0; pc_write_cond = 1; alu_zero = 1; pc_source = PCSRC_RSVD;
        do_edge();
        tests_run++; if (pc_q !== 32'h200) begin tests_failed++; $display("FAIL reserved_src_cond_hold: got %h expected %h", pc_q, 32'h200); end
    endtask

    task automatic test_counter_wrap();
        clear_inputs();
        #2;
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        for (int i = 0; i < CNT_MOD; i++) begin
            ir_write = 1; mem_rdata = $urandom;
            do_edge();
            if (i == CNT_MOD - 2) begin
                tests_run++; if (instr_count !== 4'(CNT_MOD - 1)) begin tests_failed++; $display("FAIL count_max: got %0d expected %0d", instr_count, CNT_MOD - 1); end
            end
        end
        tests_run++; if (instr_count !== 4'd0) begin tests_failed++; $display("FAIL count_wrap: got %0d expected 0", instr_count); end
        for (int i = 0; i < 5; i++) begin
            ir_write = 1; mem_rdata = $urandom;
            do_edge();
        end
        tests_run++; if (instr_count !== 4'd5) begin tests_failed++; $display("FAIL count_five: got %0d expected 5", instr_count); end
        clear_inputs();
        #2;
        rst = 0;
        model_reset();
        #1;
        tests_run++; if (instr_count !== 4'd0) begin tests_failed++; $display("FAIL count_async_reset: got %0d expected 0", instr_count); end
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            alu_zero      = $urandom_range(0, 1);
            pc_source     = 2'($urandom_range(0, 3));
            iord          = $urandom_range(0, 1);
            mem_read      = $urandom_range(0, 1);
            ir_write      = ($urandom_range(0, 2) == 0);
            alu_result    = $urandom;
            mem_rdata     = $urandom;
            #1;
            tests_run++; if (mem_addr !== (iord ? m_alu_out : m_pc)) begin tests_failed++; $display("FAIL rnd_mem_addr[%0d]: got %h expected %h", n, mem_addr, iord ? m_alu_out : m_pc); end
            do_edge();
            tests_run++; if (pc_q !== m_pc) begin tests_failed++; $display("FAIL rnd_pc[%0d]: got %h expected %h", n, pc_q, m_pc); end
            tests_run++; if (ir_q !== m_ir || mdr_q !== m_mdr) begin tests_failed++; $display("FAIL rnd_ir_mdr[%0d]: got ir=%h mdr=%h expected ir=%h mdr=%h", n, ir_q, mdr_q, m_ir, m_mdr); end
            tests_run++; if (alu_out_q !== m_alu_out) begin tests_failed++; $display("FAIL rnd_aluout[%0d]: got %h expected %h", n, alu_out_q, m_alu_out); end
            tests_run++; if (instr_count !== 4'(m_cnt)) begin tests_failed++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, instr_count, m_cnt); end
            tests_run++; if (opcode !== 6'(m_ir / 32'h0400_0000) || rs !== 5'((m_ir / 32'h20_0000) % 32) ||
                             rt !== 5'((m_ir / 32'h1_0000) % 32) || rd !== 5'((m_ir / 32'h800) % 32) ||
                             imm !== 16'(m_ir % 32'h1_0000) || jaddr !== 26'(m_ir % 32'h0400_0000)) begin
                tests_failed++;
                $display("FAIL rnd_fields[%0d]: got op=%h rs=%h rt=%h rd=%h imm=%h jaddr=%h for ir=%h", n, opcode, rs, rt, rd, imm, jaddr, m_ir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_jump();
        test_addr_priority();
        test_counter_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
